// File: rtl/game_controller_pkg.sv
// game_controller_pkg: shared state enum, shape limits and win threshold for the game controller
package game_controller_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_MASTER, WAIT_GUESS, GRADE, CHECK, DONE} ctrl_state_t;
  typedef logic [2:0] shape_t;
  localparam shape_t SHAPE_MIN = 3'd1;
  localparam shape_t SHAPE_MAX = 3'd6;
  localparam logic [3:0] WIN_ZNARLY = 4'd4;
  function automatic logic pattern_ok(input logic [11:0] p);
    pattern_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pattern_ok &= (shape_t'(p[3*i +: 3]) >= SHAPE_MIN) && (shape_t'(p[3*i +: 3]) <= SHAPE_MAX);
    end
  endfunction
endpackage

// File: rtl/game_controller_round_tracker.sv
// round_tracker: round counter, last grader result and registered win/finish outcome
// ports: clk_i/rst_ni clock and sync active-low reset; clear_i wipes all state;
//        capture_i latches znarly_i/zood_i and counts a round; check_i registers the outcome;
//        round_o/znarly_o/zood_o current values; won_o/finished_o outcome; finish_now_o combinational outcome
module round_tracker
  import game_controller_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       capture_i,
  input  logic       check_i,
  input  logic [3:0] znarly_i,
  input  logic [3:0] zood_i,
  output logic [3:0] round_o,
  output logic [3:0] znarly_o,
  output logic [3:0] zood_o,
  output logic       won_o,
  output logic       finished_o,
  output logic       finish_now_o
);
  logic [3:0] round_q, round_d, znarly_q, znarly_d, zood_q, zood_d;
  logic       won_q, won_d, fin_q, fin_d, win_now;
  assign win_now      = znarly_q == WIN_ZNARLY;
  assign finish_now_o = win_now || (round_q == 4'(MAX_ROUNDS));
  always_comb begin
    round_d  = clear_i ? 4'd0 : capture_i ? round_q + 4'd1 : round_q;
    znarly_d = clear_i ? 4'd0 : capture_i ? znarly_i : znarly_q;
    zood_d   = clear_i ? 4'd0 : capture_i ? zood_i : zood_q;
    won_d    = clear_i ? 1'b0 : check_i ? win_now : won_q;
    fin_d    = clear_i ? 1'b0 : check_i ? finish_now_o : fin_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      round_q  <= '0;
      znarly_q <= '0;
      zood_q   <= '0;
      won_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      round_q  <= round_d;
      znarly_q <= znarly_d;
      zood_q   <= zood_d;
      won_q    <= won_d;
      fin_q    <= fin_d;
    end
  end
  assign round_o    = round_q;
  assign znarly_o   = znarly_q;
  assign zood_o     = zood_q;
  assign won_o      = won_q;
  assign finished_o = fin_q;
endmodule

// File: rtl/game_controller.sv
// game_controller: sequences one game session -- master load, guess validation, grader handshake, outcome
// ports: clock/reset_L sync active-low; StartGame/LoadMaster pulses; MasterIn/Guess 4x3-bit patterns;
//        GradeIt button level; GradeDone/Znarly/Zood grader result; GradeReq grader request;
//        MasterPattern/GuessPattern latched patterns; RoundNumber/LastZnarly/LastZood round state;
//        ReadyForGuess, BadGuess, GameWon, GameFinished status
module game_controller
  import game_controller_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        StartGame,
  input  logic        LoadMaster,
  input  logic [11:0] MasterIn,
  input  logic [11:0] Guess,
  input  logic        GradeIt,
  input  logic        GradeDone,
  input  logic [3:0]  Znarly,
  input  logic [3:0]  Zood,
  output logic        GradeReq,
  output logic [11:0] MasterPattern,
  output logic [11:0] GuessPattern,
  output logic [3:0]  RoundNumber,
  output logic [3:0]  LastZnarly,
  output logic [3:0]  LastZood,
  output logic        ReadyForGuess,
  output logic        BadGuess,
  output logic        GameWon,
  output logic        GameFinished
);
  ctrl_state_t state_q, state_d;
  logic [11:0] master_q, master_d, guess_q, guess_d;
  logic        gradeit_q, bad_q, bad_d, rise, finish_now;
  // gradeit_q tracks the button every cycle so a held level never looks like a new press
  assign rise = GradeIt & ~gradeit_q;
  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    guess_d  = guess_q;
    bad_d    = 1'b0;
    if (StartGame) begin
      state_d = LOAD_MASTER;
      guess_d = '0;
    end else begin
      case (state_q)
        LOAD_MASTER: if (LoadMaster) begin
          master_d = MasterIn;
          state_d  = WAIT_GUESS;
        end
        WAIT_GUESS: if (rise) begin
          if (pattern_ok(Guess)) begin
            guess_d = Guess;
            state_d = GRADE;
          end else begin
            bad_d = 1'b1;
          end
        end
        GRADE:   state_d = GradeDone ? CHECK : GRADE;
        CHECK:   state_d = finish_now ? DONE : WAIT_GUESS;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      master_q  <= '0;
      guess_q   <= '0;
      gradeit_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      master_q  <= master_d;
      guess_q   <= guess_d;
      gradeit_q <= GradeIt;
      bad_q     <= bad_d;
    end
  end
  assign GradeReq      = state_q == GRADE;
  assign ReadyForGuess = state_q == WAIT_GUESS;
  assign BadGuess      = bad_q;
  assign MasterPattern = master_q;
  assign GuessPattern  = guess_q;
  round_tracker #(.MAX_ROUNDS(MAX_ROUNDS)) u_rounds (
    .clk_i       (clock),
    .rst_ni      (reset_L),
    .clear_i     (StartGame),
    .capture_i   (!StartGame && state_q == GRADE && GradeDone),
    .check_i     (!StartGame && state_q == CHECK),
    .znarly_i    (Znarly),
    .zood_i      (Zood),
    .round_o     (RoundNumber),
    .znarly_o    (LastZnarly),
    .zood_o      (LastZood),
    .won_o       (GameWon),
    .finished_o  (GameFinished),
    .finish_now_o(finish_now)
  );
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed stimulus against a session-level reference model with literal spot checks
module tb_game_controller;
  localparam int MAXR = 8;
  logic clock = 1'b0, reset_L = 1'b0, StartGame = 1'b0, LoadMaster = 1'b0, GradeIt = 1'b0, GradeDone = 1'b0;
  logic [11:0] MasterIn = '0, Guess = '0;
  logic [3:0] Znarly = '0, Zood = '0;
  logic GradeReq, ReadyForGuess, BadGuess, GameWon, GameFinished;
  logic [11:0] MasterPattern, GuessPattern;
  logic [3:0] RoundNumber, LastZnarly, LastZood;
  int total = 0, bad = 0;
  bit armed = 0;
  game_controller #(.MAX_ROUNDS(MAXR)) dut (
    .clock(clock), .reset_L(reset_L), .StartGame(StartGame), .LoadMaster(LoadMaster),
    .MasterIn(MasterIn), .Guess(Guess), .GradeIt(GradeIt), .GradeDone(GradeDone),
    .Znarly(Znarly), .Zood(Zood), .GradeReq(GradeReq), .MasterPattern(MasterPattern),
    .GuessPattern(GuessPattern), .RoundNumber(RoundNumber), .LastZnarly(LastZnarly),
    .LastZood(LastZood), .ReadyForGuess(ReadyForGuess), .BadGuess(BadGuess),
    .GameWon(GameWon), .GameFinished(GameFinished)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // session model: phase 0 idle, 1 awaiting master, 2 awaiting guess, 3 with grader, 4 judging, 5 over
  int m_phase, m_round, m_lz, m_lo;
  logic [11:0] m_master, m_guess;
  bit m_won, m_fin, m_bad, m_prev;
  function automatic bit legal(input logic [11:0] g);
    int v = int'(g);
    for (int i = 0; i < 4; i++) begin
      if (v % 8 == 0 || v % 8 == 7) return 0;
      v = v / 8;
    end
    return 1;
  endfunction
  always @(posedge clock) begin
    if (!reset_L) begin
      m_phase = 0; m_round = 0; m_lz = 0; m_lo = 0; m_master = 0; m_guess = 0;
      m_won = 0; m_fin = 0; m_bad = 0; m_prev = 0;
    end else begin
      bit pressed;
      pressed = GradeIt && !m_prev;
      m_prev = GradeIt;
      m_bad = 0;
      if (StartGame) begin
        m_phase = 1; m_round = 0; m_lz = 0; m_lo = 0; m_guess = 0; m_won = 0; m_fin = 0;
      end else if (m_phase == 1 && LoadMaster) begin
        m_master = MasterIn; m_phase = 2;
      end else if (m_phase == 2 && pressed) begin
        if (legal(Guess)) begin m_guess = Guess; m_phase = 3; end
        else m_bad = 1;
      end else if (m_phase == 3 && GradeDone) begin
        m_lz = Znarly; m_lo = Zood; m_round = m_round + 1; m_phase = 4;
      end else if (m_phase == 4) begin
        m_won = (m_lz == 4);
        m_fin = m_won || (m_round == MAXR);
        m_phase = m_fin ? 5 : 2;
      end
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("GradeReq", 12'(GradeReq), 12'(m_phase == 3));
      chk("ReadyForGuess", 12'(ReadyForGuess), 12'(m_phase == 2));
      chk("BadGuess", 12'(BadGuess), 12'(m_bad));
      chk("MasterPattern", MasterPattern, m_master);
      chk("GuessPattern", GuessPattern, m_guess);
      chk("RoundNumber", 12'(RoundNumber), 12'(m_round));
      chk("LastZnarly", 12'(LastZnarly), 12'(m_lz));
      chk("LastZood", 12'(LastZood), 12'(m_lo));
      chk("GameWon", 12'(GameWon), 12'(m_won));
      chk("GameFinished", 12'(GameFinished), 12'(m_fin));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask
  task automatic start();
    StartGame = 1; step(); StartGame = 0;
  endtask
  task automatic load(input logic [11:0] m);
    LoadMaster = 1; MasterIn = m; step(); LoadMaster = 0;
  endtask
  task automatic submit(input logic [11:0] g);
    Guess = g; GradeIt = 1; step(); GradeIt = 0; step();
  endtask
  task automatic grade(input logic [3:0] z, input logic [3:0] o);
    int n = 0;
    while (!GradeReq && n < 20) begin step(); n++; end
    chk("grade_req_seen", 12'(GradeReq), 12'd1);
    GradeDone = 1; Znarly = z; Zood = o; step();
    GradeDone = 0; step();
  endtask
  initial begin
    step(2);
    armed = 1;
    chk("rst_round", 12'(RoundNumber), 12'd0);
    chk("rst_master", MasterPattern, 12'd0);
    chk("rst_ready", 12'(ReadyForGuess), 12'd0);
    reset_L = 1; step();
    // immediate win
    start(); load(12'o1234); submit(12'o1234); grade(4'd4, 4'd0);
    chk("win_round", 12'(RoundNumber), 12'd1);
    chk("win_won", 12'(GameWon), 12'd1);
    chk("win_fin", 12'(GameFinished), 12'd1);
    chk("win_ready", 12'(ReadyForGuess), 12'd0);
    submit(12'o2345);
    chk("done_no_req", 12'(GradeReq), 12'd0);
    // exhaust all rounds
    start(); load(12'o6543);
    for (int r = 0; r < MAXR; r++) begin submit(12'o2345); grade(4'd1, 4'd2); end
    chk("max_round", 12'(RoundNumber), 12'd8);
    chk("max_won", 12'(GameWon), 12'd0);
    chk("max_fin", 12'(GameFinished), 12'd1);
    Guess = 12'o2345; GradeIt = 1; step();
    chk("ninth_no_req", 12'(GradeReq), 12'd0);
    GradeIt = 0; step();
    // rejected guesses
    start(); load(12'o1111);
    Guess = 12'o0123; GradeIt = 1; step();
    chk("bad0_pulse", 12'(BadGuess), 12'd1);
    GradeIt = 0; step();
    chk("bad0_gone", 12'(BadGuess), 12'd0);
    chk("bad0_ready", 12'(ReadyForGuess), 12'd1);
    Guess = 12'o7111; GradeIt = 1; step();
    chk("bad7_pulse", 12'(BadGuess), 12'd1);
    GradeIt = 0; step();
    chk("bad7_round", 12'(RoundNumber), 12'd0);
    // held button with slow grader
    begin
      int req_cycles = 0;
      Guess = 12'o3456; GradeIt = 1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (GradeReq) req_cycles++;
        GradeDone = GradeReq && req_cycles == 4;
        Znarly = 4'd2; Zood = 4'd1;
      end
      GradeIt = 0; GradeDone = 0; step();
      chk("held_req_cycles", 12'(req_cycles), 12'd4);
      chk("held_round", 12'(RoundNumber), 12'd1);
    end
    // illegal Znarly above four is not a win, then restart mid-grade at round 3
    submit(12'o1111); grade(4'd5, 4'd0);
    chk("z5_won", 12'(GameWon), 12'd0);
    submit(12'o6666); grade(4'd0, 4'd3);
    chk("r3_round", 12'(RoundNumber), 12'd3);
    submit(12'o1212); step(2);
    chk("mid_req", 12'(GradeReq), 12'd1);
    start();
    chk("restart_req", 12'(GradeReq), 12'd0);
    chk("restart_round", 12'(RoundNumber), 12'd0);
    chk("restart_master", MasterPattern, 12'o1111);
    GradeDone = 1; Znarly = 4'd4; step(); GradeDone = 0;
    chk("late_done_round", 12'(RoundNumber), 12'd0);
    // reset mid-game
    load(12'o2222); submit(12'o2323); grade(4'd1, 4'd1);
    reset_L = 0; step(); reset_L = 1;
    chk("rst2_round", 12'(RoundNumber), 12'd0);
    chk("rst2_master", MasterPattern, 12'd0);
    load(12'o3333); submit(12'o3434);
    chk("rst2_ignored_master", MasterPattern, 12'd0);
    chk("rst2_no_req", 12'(GradeReq), 12'd0);
    start(); load(12'o4444);
    chk("rst2_ready", 12'(ReadyForGuess), 12'd1);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
